// File: rtl/dfi_log_table_responder.sv
// DFI log-table responder: circular record table written by instrumentation,
// read back by the checker through a three-state request FSM.
module dfi_log_table_responder #(
  parameter int N_ADDR_WIDTH = 32,
  parameter int N_DATA_WIDTH = 32,
  parameter int N_LOGID_WIDTH = 8,
  parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDRINIT = 32'h1FEFFC00,
  parameter logic [N_ADDR_WIDTH-1:0] LOGTABLE_ADDREND = 32'h1FEFFFF8,
  parameter int N_CNT_WIDTH = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_wrValid,
  input  logic [N_LOGID_WIDTH-1:0]              i_wrLogId,
  input  logic [N_DATA_WIDTH-1:0]               i_wrData,
  output logic                                  o_wrReady,
  output logic                                  o_trigger,
  output logic [N_ADDR_WIDTH-1:0]               o_logAddrptr,
  input  logic                                  i_rqAccess,
  input  logic [N_ADDR_WIDTH-1:0]               i_logAddr,
  output logic                                  o_logDone,
  output logic [N_LOGID_WIDTH+N_DATA_WIDTH-1:0] o_logData,
  output logic                                  o_rdErr,
  input  logic                                  i_invWrite,
  output logic                                  o_invFlag,
  output logic [N_CNT_WIDTH-1:0]                o_invCount,
  output logic [N_CNT_WIDTH-1:0]                o_entryCount,
  output logic [N_CNT_WIDTH-1:0]                o_wrapCount
);

  localparam int REC_W = N_LOGID_WIDTH + N_DATA_WIDTH;
  localparam int DEPTH =
    int'((LOGTABLE_ADDREND - LOGTABLE_ADDRINIT) >> 3) + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [N_CNT_WIDTH-1:0] DEPTH_C = N_CNT_WIDTH'(DEPTH);
  localparam logic [N_CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LATCH,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [REC_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]        wptr;
  logic                    wr_fire;
  logic [N_ADDR_WIDTH-1:0] rd_addr;
  logic [N_ADDR_WIDTH-1:0] rd_off;
  logic [IDX_W-1:0]        rd_idx;
  logic                    rd_legal;
  logic                    rd_latch;
  logic                    rd_fetch;
  logic                    rd_done;
  logic [REC_W-1:0]        rd_data;
  logic                    rd_err;

  // The producer is never back-pressured; ready only drops while in reset.
  assign o_wrReady = ~rst;
  assign wr_fire   = i_wrValid & o_wrReady;

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wptr] <= {i_wrLogId, i_wrData};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      o_trigger    <= 1'b0;
      o_logAddrptr <= LOGTABLE_ADDREND;
      o_entryCount <= '0;
      o_wrapCount  <= '0;
    end else begin
      o_trigger <= wr_fire;
      if (wr_fire) begin
        o_logAddrptr <= LOGTABLE_ADDRINIT
                      + N_ADDR_WIDTH'({wptr, 3'b000});
        if (wptr == LAST_IDX) begin
          wptr <= '0;
          if (o_wrapCount != CNT_MAX) begin
            o_wrapCount <= o_wrapCount + 1'b1;
          end
        end else begin
          wptr <= wptr + 1'b1;
        end
        if (o_entryCount != DEPTH_C) begin
          o_entryCount <= o_entryCount + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rd_latch  = 1'b0;
    rd_fetch  = 1'b0;
    rd_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_rqAccess) begin
          rd_latch  = 1'b1;
          state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        rd_fetch  = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        rd_done   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign rd_off   = rd_addr - LOGTABLE_ADDRINIT;
  assign rd_idx   = IDX_W'(rd_off >> 3);
  assign rd_legal = (rd_addr >= LOGTABLE_ADDRINIT)
                  && (rd_addr <= LOGTABLE_ADDREND)
                  && (rd_addr[2:0] == 3'b000);

  // Fetch happens one edge after acceptance, so a same-edge write is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
      rd_data <= '0;
      rd_err  <= 1'b0;
    end else begin
      if (rd_latch) begin
        rd_addr <= i_logAddr;
      end
      if (rd_fetch) begin
        if (rd_legal) begin
          rd_data <= mem[rd_idx];
          rd_err  <= 1'b0;
        end else begin
          rd_data <= '0;
          rd_err  <= 1'b1;
        end
      end
    end
  end

  assign o_logDone = rd_done;
  assign o_logData = rd_data;
  assign o_rdErr   = rd_done & rd_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_invFlag  <= 1'b0;
      o_invCount <= '0;
    end else if (i_invWrite) begin
      o_invFlag <= 1'b1;
      if (o_invCount != CNT_MAX) begin
        o_invCount <= o_invCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dfi_log_table_responder.sv
// Bench for dfi_log_table_responder: directed tables, corner sequences and
// randomized traffic against a behavioural table/read model.
module tb_dfi_log_table_responder;

  localparam logic [31:0] INIT  = 32'h1FEFFC00;
  localparam logic [31:0] LAST  = 32'h1FEFFFF8;
  localparam int          DEPTH = 128;

  logic        clk;
  logic        rst;
  logic        i_wrValid;
  logic [7:0]  i_wrLogId;
  logic [31:0] i_wrData;
  logic        o_wrReady;
  logic        o_trigger;
  logic [31:0] o_logAddrptr;
  logic        i_rqAccess;
  logic [31:0] i_logAddr;
  logic        o_logDone;
  logic [39:0] o_logData;
  logic        o_rdErr;
  logic        i_invWrite;
  logic        o_invFlag;
  logic [15:0] o_invCount;
  logic [15:0] o_entryCount;
  logic [15:0] o_wrapCount;

  dfi_log_table_responder dut (
    .clk(clk),
    .rst(rst),
    .i_wrValid(i_wrValid),
    .i_wrLogId(i_wrLogId),
    .i_wrData(i_wrData),
    .o_wrReady(o_wrReady),
    .o_trigger(o_trigger),
    .o_logAddrptr(o_logAddrptr),
    .i_rqAccess(i_rqAccess),
    .i_logAddr(i_logAddr),
    .o_logDone(o_logDone),
    .o_logData(o_logData),
    .o_rdErr(o_rdErr),
    .i_invWrite(i_invWrite),
    .o_invFlag(o_invFlag),
    .o_invCount(o_invCount),
    .o_entryCount(o_entryCount),
    .o_wrapCount(o_wrapCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: table contents plus total write count since reset.
  logic [39:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  int          m_wcount;
  int          m_inv;
  bit          m_trig;
  logic [31:0] m_aptr;
  int          m_phase;
  logic [31:0] m_addr;
  logic [39:0] m_data;
  bit          m_err;
  bit          m_known;

  typedef struct {
    logic [31:0] addr;
    logic [39:0] data;
    logic        err;
  } rd_vec_t;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [31:0] aptr;
  } wr_vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a >= INIT) && (a <= LAST) && (a[2:0] == 3'b000);
  endfunction

  function automatic void model_reset();
    m_wcount = 0;
    m_inv    = 0;
    m_trig   = 0;
    m_aptr   = LAST;
    m_phase  = 0;
    m_data   = '0;
    m_err    = 0;
    m_known  = 1;
  endfunction

  function automatic void model_edge();
    int p;
    int k;
    m_trig = 0;
    if (m_phase == 2) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (legal(m_addr)) begin
        k       = int'((m_addr - INIT) / 8);
        m_data  = m_mem[k];
        m_known = m_wr[k];
        m_err   = 0;
      end else begin
        m_data  = '0;
        m_known = 1;
        m_err   = 1;
      end
      m_phase = 2;
    end else if (i_rqAccess) begin
      m_addr  = i_logAddr;
      m_phase = 1;
    end
    if (i_wrValid) begin
      p        = m_wcount % DEPTH;
      m_mem[p] = {i_wrLogId, i_wrData};
      m_wr[p]  = 1;
      m_aptr   = INIT + 32'(8 * p);
      m_wcount++;
      m_trig   = 1;
    end
    if (i_invWrite && m_inv < 65535) m_inv++;
  endfunction

  task automatic cycle();
    int ent;
    @(posedge clk);
    model_edge();
    #1;
    ent = (m_wcount > DEPTH) ? DEPTH : m_wcount;
    chk("trigger", o_trigger, m_trig);
    if (m_trig) chk("addrptr", o_logAddrptr, m_aptr);
    chk("logdone", o_logDone, m_phase == 2);
    if (m_phase == 2) begin
      chk("rderr", o_rdErr, m_err);
      if (m_known) chk("logdata", o_logData, m_data);
    end else begin
      chk("rderr_idle", o_rdErr, 0);
    end
    chk("entrycount", o_entryCount, ent);
    chk("wrapcount", o_wrapCount, m_wcount / DEPTH);
    chk("invcount", o_invCount, m_inv);
    chk("invflag", o_invFlag, m_inv != 0);
  endtask

  task automatic do_read(input logic [31:0] a,
                         output logic [39:0] d, output logic e);
    i_rqAccess = 1'b1;
    i_logAddr  = a;
    cycle();
    i_rqAccess = 1'b0;
    chk("done_early", o_logDone, 0);
    cycle();
    chk("done_t2", o_logDone, 1);
    d = o_logData;
    e = o_rdErr;
    cycle();
    chk("done_pulse", o_logDone, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time budget exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    rd_vec_t     rtab [5];
    wr_vec_t     wtab [4];
    logic [39:0] d;
    logic        e;
    logic [39:0] old;
    int          j;

    wtab[0] = '{8'h03, 32'h5, 32'h1FEFFC00};
    wtab[1] = '{8'h03, 32'h5, 32'h1FEFFC08};
    wtab[2] = '{8'h03, 32'h5, 32'h1FEFFC10};
    wtab[3] = '{8'h03, 32'h5, 32'h1FEFFC18};
    rtab[0] = '{32'h1FEFFC18, 40'h0300000005, 1'b0};
    rtab[1] = '{32'h1FEFFC1C, 40'h0, 1'b1};
    rtab[2] = '{32'h1FF00000, 40'h0, 1'b1};
    rtab[3] = '{32'h1FEFFBF8, 40'h0, 1'b1};
    rtab[4] = '{32'h1FEFFC00, 40'h0300000005, 1'b0};

    for (int i = 0; i < DEPTH; i++) m_wr[i] = 0;
    rst        = 1'b1;
    i_wrValid  = 1'b0;
    i_wrLogId  = '0;
    i_wrData   = '0;
    i_rqAccess = 1'b0;
    i_logAddr  = '0;
    i_invWrite = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", o_wrReady, 0);
    chk("rst_trig", o_trigger, 0);
    chk("rst_aptr", o_logAddrptr, 32'h1FEFFFF8);
    chk("rst_data", o_logData, 0);
    chk("rst_entry", o_entryCount, 0);
    rst = 1'b0;
    #1;
    chk("ready", o_wrReady, 1);

    // Four back-to-back writes.
    foreach (wtab[i]) begin
      i_wrValid = 1'b1;
      i_wrLogId = wtab[i].id;
      i_wrData  = wtab[i].data;
      cycle();
      chk("wr_trig", o_trigger, 1);
      chk("wr_aptr", o_logAddrptr, wtab[i].aptr);
    end
    i_wrValid = 1'b0;
    cycle();
    chk("wr_trig_off", o_trigger, 0);
    chk("wr_entry4", o_entryCount, 4);

    foreach (rtab[i]) begin
      do_read(rtab[i].addr, d, e);
      chk("tab_data", d, rtab[i].data);
      chk("tab_err", e, rtab[i].err);
    end

    i_invWrite = 1'b1;
    repeat (3) cycle();
    i_invWrite = 1'b0;
    cycle();
    chk("inv_count3", o_invCount, 3);
    chk("inv_flag", o_invFlag, 1);

    // Reset while a read sits in LATCH: no response may appear.
    i_rqAccess = 1'b1;
    i_logAddr  = 32'h1FEFFC08;
    cycle();
    i_rqAccess = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_done", o_logDone, 0);
    chk("mid_rst_aptr", o_logAddrptr, 32'h1FEFFFF8);
    chk("mid_rst_inv", o_invCount, 0);
    chk("mid_rst_flag", o_invFlag, 0);
    chk("mid_rst_entry", o_entryCount, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_done2", o_logDone, 0);
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      cycle();
      chk("post_rst_done", o_logDone, 0);
    end

    // 130 writes: wrap once, entry 0 overwritten by write 129.
    for (int k = 1; k <= 130; k++) begin
      i_wrValid = 1'b1;
      i_wrLogId = 8'h10;
      i_wrData  = 32'(k);
      cycle();
    end
    i_wrValid = 1'b0;
    cycle();
    chk("wrap1", o_wrapCount, 1);
    chk("entry128", o_entryCount, 128);
    chk("aptr_wrap", o_logAddrptr, 32'h1FEFFC08);
    do_read(32'h1FEFFC00, d, e);
    chk("entry0_data", d, 40'h1000000081);

    // Write and read of the same index accepted on the same edge.
    j          = m_wcount % DEPTH;
    i_wrValid  = 1'b1;
    i_wrLogId  = 8'h04;
    i_wrData   = 32'h40;
    i_rqAccess = 1'b1;
    i_logAddr  = INIT + 32'(8 * j);
    cycle();
    i_wrValid  = 1'b0;
    i_rqAccess = 1'b0;
    cycle();
    chk("coll_done", o_logDone, 1);
    chk("coll_data", o_logData, 40'h0400000040);
    cycle();

    // Write during LATCH to the read index returns the old record.
    j          = m_wcount % DEPTH;
    old        = m_mem[j];
    i_rqAccess = 1'b1;
    i_logAddr  = INIT + 32'(8 * j);
    cycle();
    i_rqAccess = 1'b0;
    i_wrValid  = 1'b1;
    i_wrLogId  = 8'h05;
    i_wrData   = 32'hABCD;
    cycle();
    i_wrValid  = 1'b0;
    chk("rf_done", o_logDone, 1);
    chk("rf_data", o_logData, old);
    cycle();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      i_wrValid  = ($urandom_range(0, 1) == 1);
      i_wrLogId  = 8'($urandom);
      i_wrData   = $urandom;
      i_invWrite = ($urandom_range(0, 9) == 0);
      i_rqAccess = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 7))
        0: i_logAddr = INIT + 32'($urandom_range(0, 1023));
        1: i_logAddr = INIT - 32'(8 * $urandom_range(1, 4));
        2: i_logAddr = LAST + 32'(8 * $urandom_range(1, 4));
        default: i_logAddr = INIT + 32'(8 * $urandom_range(0, DEPTH - 1));
      endcase
      cycle();
    end
    i_wrValid  = 1'b0;
    i_rqAccess = 1'b0;
    i_invWrite = 1'b0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
